// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states, digit codes
// and the 3-bit window recoder.
package booth_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } digit_t;

  function automatic digit_t booth_recode(input logic [2:0] win);
    digit_t d;
    case (win)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Partial-product selector: turns a Booth digit into an adder operand plus carry-in.
// Negative digits are inverted here; the +1 rides on the accumulator adder's carry-in.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  digit_t         digit,
  input  logic [W+1:0]   mcand,
  output logic [W+1:0]   operand,
  output logic           cin
);

  logic [W+1:0] mcand_x2;

  assign mcand_x2 = {mcand[W:0], 1'b0};

  always_comb begin
    operand = '0;
    cin     = 1'b0;
    unique case (digit)
      BD_POS1: operand = mcand;
      BD_POS2: operand = mcand_x2;
      BD_NEG1: begin
        operand = ~mcand;
        cin     = 1'b1;
      end
      BD_NEG2: begin
        operand = ~mcand_x2;
        cin     = 1'b1;
      end
      default: operand = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one digit per RUN cycle through a shared recoder
// and adder, with a start/busy/done handshake and a held product register.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   p
);

  localparam int unsigned Steps = W / 2;
  localparam int unsigned CW    = (Steps > 1) ? $clog2(Steps) : 1;
  localparam int unsigned AW    = 2 * W + 2;
  localparam logic [CW-1:0] LastStep = CW'(Steps - 1);

  if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
    $error("booth_seq_mul: W must be even and at least 4");
  end

  state_t          state_q;
  logic [W+1:0]    mcand_q;
  logic [W:0]      mplier_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  p_q;

  digit_t          digit;
  logic [W+1:0]    operand;
  logic            cin;
  logic [CW:0]     shamt;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   cin_vec;
  logic [AW-1:0]   acc_sum;

  assign digit = booth_recode(mplier_q[2:0]);

  booth_pp_sel #(
    .W (W)
  ) u_pp_sel (
    .digit   (digit),
    .mcand   (mcand_q),
    .operand (operand),
    .cin     (cin)
  );

  // Weight 4^i: shift the sign-extended operand and its carry-in by 2*i.
  always_comb begin
    shamt   = {cnt_q, 1'b0};
    addend  = {{W{operand[W+1]}}, operand} << shamt;
    cin_vec = AW'(cin) << shamt;
    acc_sum = acc_q + addend + cin_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= RUN;
            mcand_q  <= {{2{a[W-1]}}, a};
            mplier_q <= {b, 1'b0};
            acc_q    <= '0;
            cnt_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_sum;
          mplier_q <= {2'b00, mplier_q[W:2]};
          if (cnt_q == LastStep) begin
            state_q <= DONE;
            p_q     <= acc_sum[2*W-1:0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule
